// File: rtl/program_loader.sv
// Byte-stream program loader: parses SYNC/ADDR/LEN/data/CSUM frames, writes program
// memory and holds the CPU until a frame with a valid checksum has landed.
module program_loader #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]            mem_wdata,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_LEN,
        S_DATA,
        S_CSUM,
        S_RUN
    } state_t;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] ptr_q;
    logic [7:0]            cnt_q;
    logic [7:0]            sum_q;
    logic                  in_ready_q;
    logic                  mem_we_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [7:0]            mem_wdata_q;
    logic                  cpu_hold_q;
    logic                  done_q;
    logic                  error_q;

    logic                  accept;
    logic [7:0]            sum_next;

    assign accept   = in_valid && in_ready_q;
    assign sum_next = sum_q + in_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            cnt_q       <= '0;
            sum_q       <= '0;
            in_ready_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_hold_q  <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            in_ready_q <= 1'b1;
            mem_we_q   <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            if (accept) begin
                unique case (state_q)
                    S_IDLE: begin
                        if (in_data == SYNC_BYTE) state_q <= S_ADDR;
                    end
                    S_ADDR: begin
                        ptr_q   <= ADDR_WIDTH'(in_data);
                        sum_q   <= in_data;
                        state_q <= S_LEN;
                    end
                    S_LEN: begin
                        cnt_q   <= in_data;
                        sum_q   <= sum_next;
                        state_q <= (in_data != 8'd0) ? S_DATA : S_CSUM;
                    end
                    S_DATA: begin
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= ptr_q;
                        mem_wdata_q <= in_data;
                        ptr_q       <= ptr_q + 1'b1;
                        sum_q       <= sum_next;
                        cnt_q       <= cnt_q - 8'd1;
                        if (cnt_q == 8'd1) state_q <= S_CSUM;
                    end
                    S_CSUM: begin
                        if (sum_next == 8'd0) begin
                            done_q     <= 1'b1;
                            cpu_hold_q <= 1'b0;
                            state_q    <= S_RUN;
                        end else begin
                            error_q <= 1'b1;
                            state_q <= S_IDLE;
                        end
                    end
                    S_RUN: begin
                        // A new frame while running re-stalls the CPU before any byte is written.
                        if (in_data == SYNC_BYTE) begin
                            cpu_hold_q <= 1'b1;
                            state_q    <= S_ADDR;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_hold  = cpu_hold_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: directed frames plus random frames, checked against a
// frame-level model of expected writes, completion pulses and CPU hold.
module tb_program_loader;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       cpu_hold;
    logic       done;
    logic       error;

    program_loader #(.ADDR_WIDTH(8), .SYNC_BYTE(8'hA5)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .cpu_hold(cpu_hold), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad = 0;
    logic [7:0] exp_mem [256];
    logic [7:0] dut_mem [256];
    logic [7:0] last_addr;
    logic [7:0] last_wdata;
    logic       hold_m;
    logic [7:0] q [$];

    always @(posedge clk) if (mem_we === 1'b1) dut_mem[mem_addr] <= mem_wdata;

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input int gap, input logic we,
                        input logic [7:0] a, input logic [7:0] wd,
                        input logic dn, input logic er, input logic hold);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        if (we) begin
            last_addr  = a;
            last_wdata = wd;
            exp_mem[a] = wd;
        end
        chk("mem_we", mem_we, we);
        chk("mem_addr", mem_addr, last_addr);
        chk("mem_wdata", mem_wdata, last_wdata);
        chk("done", done, dn);
        chk("error", error, er);
        chk("cpu_hold", cpu_hold, hold);
        chk("in_ready", in_ready, 1'b1);
        for (int i = 0; i < gap; i++) begin
            @(posedge clk);
            #1;
            chk("gap_we", mem_we, 1'b0);
            chk("gap_done", done, 1'b0);
            chk("gap_error", error, 1'b0);
            chk("gap_hold", cpu_hold, hold);
            chk("gap_addr", mem_addr, last_addr);
        end
    endtask

    task automatic noise(input logic [7:0] b, input int gap);
        send(b, gap, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, hold_m);
    endtask

    // Expected behaviour derived from the frame as a whole: writes land at addr+i mod 256,
    // and the frame is good exactly when all of ADDR, LEN, data and CSUM sum to zero.
    task automatic send_frame(input logic [7:0] a, input logic [7:0] d [$],
                              input logic [7:0] cs, input int gap);
        int unsigned s;
        logic        ok;
        hold_m = 1'b1;
        send(8'hA5, gap, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        send(a, gap, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        send(8'(d.size()), gap, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        s = a + d.size();
        for (int i = 0; i < d.size(); i++) begin
            send(d[i], gap, 1'b1, 8'((a + i) % 256), d[i], 1'b0, 1'b0, 1'b1);
            s += d[i];
        end
        ok = ((s + cs) % 256) == 0;
        send(cs, gap, 1'b0, 8'h00, 8'h00, ok, !ok, !ok);
        hold_m = !ok;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        last_addr  = 8'h00;
        last_wdata = 8'h00;
        hold_m     = 1'b1;
        chk("rst_hold", cpu_hold, 1'b1);
        chk("rst_ready", in_ready, 1'b0);
        chk("rst_we", mem_we, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_error", error, 1'b0);
        chk("rst_addr", mem_addr, 8'h00);
        chk("rst_wdata", mem_wdata, 8'h00);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("ready_after_reset", in_ready, 1'b1);
        chk("we_after_reset", mem_we, 1'b0);
    endtask

    initial begin
        int         n;
        logic [7:0] a;
        logic [7:0] cs;
        int unsigned s;
        for (int i = 0; i < 256; i++) begin
            exp_mem[i] = 8'h00;
            dut_mem[i] = 8'h00;
        end
        do_reset();

        // good frame
        q.delete(); q.push_back(8'h0C); q.push_back(8'h0A); q.push_back(8'h1C); q.push_back(8'h14);
        send_frame(8'h00, q, 8'hB6, 0);
        // address wrap
        q.delete(); q.push_back(8'h11); q.push_back(8'h22); q.push_back(8'h33);
        send_frame(8'hFE, q, 8'h99, 0);
        // zero length
        q.delete();
        send_frame(8'h10, q, 8'hF0, 0);
        // bad checksum, then the correct frame again
        q.delete(); q.push_back(8'h0C); q.push_back(8'h0A); q.push_back(8'h1C); q.push_back(8'h14);
        send_frame(8'h00, q, 8'hB7, 0);
        send_frame(8'h00, q, 8'hB6, 0);
        // noise and gaps from IDLE
        do_reset();
        noise(8'h00, 3);
        noise(8'hFF, 3);
        send_frame(8'h00, q, 8'hB6, 3);

        // reset mid-frame
        do_reset();
        send(8'hA5, 0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        send(8'h00, 0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        send(8'h04, 0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        send(8'h0C, 0, 1'b1, 8'h00, 8'h0C, 1'b0, 1'b0, 1'b1);
        do_reset();
        send_frame(8'h00, q, 8'hB6, 0);
        // reload while running
        q.delete(); q.push_back(8'h55);
        send_frame(8'h00, q, 8'hAA, 0);

        // reset coinciding with CSUM acceptance: no pulse
        send(8'hA5, 0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        send(8'h20, 0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        send(8'h01, 0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        send(8'h77, 0, 1'b1, 8'h20, 8'h77, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h68;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("rstcsum_done", done, 1'b0);
        chk("rstcsum_error", error, 1'b0);
        chk("rstcsum_hold", cpu_hold, 1'b1);
        do_reset();

        // random frames with noise and gaps, from both IDLE and RUN
        for (int k = 0; k < 25; k++) begin
            n = $urandom_range(0, 2);
            for (int j = 0; j < n; j++) begin
                a = 8'($urandom);
                if (a == 8'hA5) a = 8'h5A;
                noise(a, $urandom_range(0, 1));
            end
            a = 8'($urandom);
            q.delete();
            n = $urandom_range(0, 6);
            s = a + n;
            for (int j = 0; j < n; j++) begin
                q.push_back(8'($urandom));
                s += q[j];
            end
            cs = 8'((256 - (s % 256)) % 256);
            if ($urandom_range(0, 3) == 0) cs = cs + 8'($urandom_range(1, 255));
            send_frame(a, q, cs, $urandom_range(0, 2));
        end

        for (int i = 0; i < 256; i++) chk("mem", dut_mem[i], exp_mem[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/program_loader.md
# program_loader

Byte-stream program loader that fills the CPU's 256-byte program memory and releases the CPU to run. Sits between a host byte source (UART receiver or testbench) and the memory write port. The CPU is the reader of program memory and the loader is its writer. The loader holds the CPU in reset/stall (`cpu_hold`) until a complete frame with a valid checksum has been written.

## Interface

Parameters:
- `ADDR_WIDTH`, default 8: program memory address width. Memory depth is 2^ADDR_WIDTH.
- `SYNC_BYTE`, default 8'hA5: frame start marker.

Ports:
- `clk` input, 1: single clock; all state changes on the rising edge.
- `reset` input, 1: synchronous, active-high.
- `in_data` input, 8: incoming byte.
- `in_valid` input, 1: `in_data` is valid this cycle.
- `in_ready` output, 1: loader accepts a byte this cycle. A byte transfers when `in_valid && in_ready` at a rising edge.
- `mem_we` output, 1: program memory write strobe, one cycle per data byte.
- `mem_addr` output, ADDR_WIDTH: write address.
- `mem_wdata` output, 8: write data.
- `cpu_hold` output, 1: CPU must stay at pc=0 and not fetch while high.
- `done` output, 1: one-cycle pulse when a frame completes with a good checksum.
- `error` output, 1: one-cycle pulse when a frame completes with a bad checksum.

## Operation

Frame format: `SYNC`, `ADDR`, `LEN`, `LEN` data bytes, `CSUM`.
- Checksum rule: the 8-bit sum, modulo 256, of ADDR + LEN + data bytes + CSUM must equal 0.
- `LEN` = 0 means no data bytes; the next byte after `LEN` is `CSUM`.

States:
- IDLE
  - Non-sync bytes are accepted and discarded.
  - `SYNC_BYTE` → ADDR.
- ADDR
  - Latch the write pointer.
  - Initialise the running sum to the byte value.
  - → LEN.
- LEN
  - Latch the remaining count.
  - Add the byte to the running sum.
  - → DATA if nonzero, else → CSUM.
- DATA
  - Each accepted byte issues a write to the current pointer and adds to the sum.
  - Pointer increments modulo 2^ADDR_WIDTH (0xFF wraps to 0x00).
  - Count decrements; on the last byte → CSUM.
- CSUM
  - If sum + byte == 0: pulse `done`, drop `cpu_hold`, → RUN.
  - Otherwise: pulse `error`, keep `cpu_hold` high, → IDLE.
- RUN
  - `cpu_hold` = 0.
  - Non-sync bytes are discarded.
  - `SYNC_BYTE` raises `cpu_hold` in the next cycle and → ADDR (reload while running).

Additional rules:
- The data byte value equal to `SYNC_BYTE` has no special meaning outside IDLE and RUN.
- Memory writes are not rolled back on checksum failure. The only consequence of a failure is that `cpu_hold` remains asserted.

## Timing

Reset values:
- `cpu_hold` = 1.
- `in_ready` = 0.
- `mem_we`, `done`, `error` = 0.
- `mem_addr`, `mem_wdata` = 0.
- State = IDLE.

Handshake:
- `in_ready` rises in the first cycle after `reset` deasserts and stays 1 (one byte per cycle, no backpressure).
- `in_valid` may drop at any point mid-frame. The state and the running sum hold unchanged across gaps; there is no timeout.

Writes:
- `mem_we`, `mem_addr` and `mem_wdata` are registered.
- A data byte accepted at edge N appears with `mem_we`=1 in the cycle after edge N.
- `mem_we` lasts exactly one cycle.
- `mem_addr`/`mem_wdata` hold their last values when `mem_we`=0.

Completion:
- `done`/`error` are high for exactly the one cycle following the edge that accepts `CSUM`.
- `cpu_hold` falls in that same cycle as `done`.
- Latency from the last data byte's write strobe to `done`: one accepted byte (`CSUM`) later.

Reset:
- `reset` mid-frame forces the reset values on the next edge and abandons the frame.
- Writes already issued stay in memory.
- Simultaneous `reset` and `CSUM` acceptance: reset wins; no pulse.

## Test plan

- **Good frame:** send A5 00 04 0C 0A 1C 14 B6 back-to-back.
  - Required: writes mem[0..3] = 0C,0A,1C,14 on four consecutive cycles.
  - Required: `done` pulses once; `cpu_hold` goes 0; `error` stays 0.
- **Address wrap:** send A5 FE 03 11 22 33 99.
  - Required: writes FE←11, FF←22, 00←33; then `done`.
- **Zero length:** send A5 10 00 F0.
  - Required: no `mem_we`; `done` pulses; `cpu_hold` goes 0.
- **Bad checksum:** send the good frame with B7 as the last byte.
  - Required: four writes still occur; `error` pulses; `done` stays 0; `cpu_hold` stays 1; state returns to IDLE.
  - Follow-up: resending the correct frame then yields `done`.
- **Gaps and noise:** send 00 FF before the good frame, with 3 idle cycles (`in_valid`=0) between each frame byte.
  - Required: leading bytes are ignored; same four writes and `done` as the good-frame case.
- **Reset mid-frame, then reload in RUN:**
  - Assert `reset` after A5 00 04 0C. Required: `cpu_hold`=1 and no further writes.
  - Then send the good frame, then A5 00 01 55 AA while in RUN. Required: `cpu_hold` re-asserts after A5; mem[0]←55; `done` pulses again.
